// File: rtl/dp_sequencer.sv
// dp_sequencer: turns register-level commands into alu_reg control words.
// Every command is accepted only in IDLE, then expanded into one or more
// single-cycle control words, and ends with a one-cycle response pulse.
module dp_sequencer #(
  parameter int XZR      = 31,
  parameter int SCRATCH  = 27,
  parameter int MUL_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rn,
  input  logic [4:0]  cmd_rm,
  input  logic [15:0] cmd_imm,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [3:0]  flags,
  input  logic [3:0]  dp_status,
  output logic [63:0] dp_k,
  output logic [4:0]  dp_fs,
  output logic [4:0]  dp_addrR,
  output logic [4:0]  dp_addrA,
  output logic [4:0]  dp_addrB,
  output logic        dp_s,
  output logic        dp_sd,
  output logic        dp_sb,
  output logic        dp_c0,
  output logic        dp_w
);

  typedef enum logic [2:0] {IDLE, EXEC, M_CLR, M_SHF, M_ACC, RESP} state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOADI = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_ORR   = 4'd5;
  localparam logic [3:0] OP_EOR   = 4'd6;
  localparam logic [3:0] OP_LSL   = 4'd7;
  localparam logic [3:0] OP_LSR   = 4'd8;
  localparam logic [3:0] OP_ADDI  = 4'd9;
  localparam logic [3:0] OP_SUBI  = 4'd10;
  localparam logic [3:0] OP_CMP   = 4'd11;
  localparam logic [3:0] OP_MULI  = 4'd12;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [4:0] XZR_A = 5'(XZR);
  localparam logic [4:0] SCR_A = 5'(SCRATCH);
  localparam int         IW    = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(MUL_BITS - 1);

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [4:0]    rd_q, rn_q, rm_q;
  logic [15:0]   imm_q;
  logic          err_q;
  logic [IW-1:0] bit_q;
  logic [3:0]    flags_q;

  logic                accept;
  logic                cmd_illegal;
  logic                muli_bad;
  logic                cmd_bad;
  logic [MUL_BITS-1:0] mult;
  logic [MUL_BITS-1:0] mult_sel;
  logic                cur_bit;
  logic                last_bit;

  assign cmd_ready   = (state == IDLE) & ~rst;
  assign accept      = cmd_valid & cmd_ready;
  assign cmd_illegal = (cmd_op > OP_MULI);
  assign muli_bad    = (cmd_op == OP_MULI) &&
                       ((cmd_rd == cmd_rn) || (cmd_rd == SCR_A) || (cmd_rn == SCR_A));
  assign cmd_bad     = cmd_illegal | muli_bad;
  assign mult        = imm_q[MUL_BITS-1:0];
  assign mult_sel    = MUL_BITS'(1) << bit_q;
  assign cur_bit     = |(mult & mult_sel);
  assign last_bit    = (bit_q == LAST_BIT);
  assign busy        = (state != IDLE);
  assign flags       = flags_q;
  assign dp_sb       = 1'b0;

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Command latch, multiplier bit index and compare flags capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
      bit_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rn_q  <= cmd_rn;
        rm_q  <= cmd_rm;
        imm_q <= cmd_imm;
        err_q <= cmd_bad;
      end
      if (state == EXEC && op_q == OP_CMP) flags_q <= dp_status;
      if (state == M_CLR) bit_q <= '0;
      else if ((state == M_SHF && !cur_bit) || state == M_ACC) bit_q <= bit_q + 1'b1;
    end
  end

  // Next-state: rejected commands skip straight to the response cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_bad)                 state_nx = RESP;
          else if (cmd_op == OP_MULI)  state_nx = M_CLR;
          else                         state_nx = EXEC;
        end
      end
      EXEC:  state_nx = RESP;
      M_CLR: state_nx = M_SHF;
      M_SHF: begin
        if (cur_bit)       state_nx = M_ACC;
        else if (last_bit) state_nx = RESP;
        else               state_nx = M_SHF;
      end
      M_ACC: state_nx = last_bit ? RESP : M_SHF;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control word and response outputs, decoded from registered state only.
  always_comb begin
    dp_k      = '0;
    dp_fs     = FS_ADD;
    dp_addrR  = '0;
    dp_addrA  = '0;
    dp_addrB  = '0;
    dp_s      = 1'b0;
    dp_sd     = 1'b0;
    dp_c0     = 1'b0;
    dp_w      = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      EXEC: begin
        dp_sd    = 1'b1;
        dp_addrA = rn_q;
        dp_addrB = rm_q;
        dp_addrR = rd_q;
        case (op_q)
          OP_LOADI: begin
            dp_fs = FS_ADD; dp_s = 1'b1; dp_k = {48'd0, imm_q};
            dp_addrA = XZR_A; dp_w = 1'b1;
          end
          OP_ADD:  begin dp_fs = FS_ADD; dp_w = 1'b1; end
          OP_SUB:  begin dp_fs = FS_SUB; dp_c0 = 1'b1; dp_w = 1'b1; end
          OP_AND:  begin dp_fs = FS_AND; dp_w = 1'b1; end
          OP_ORR:  begin dp_fs = FS_ORR; dp_w = 1'b1; end
          OP_EOR:  begin dp_fs = FS_EOR; dp_w = 1'b1; end
          OP_LSL: begin
            dp_fs = FS_LSL; dp_s = 1'b1; dp_k = {58'd0, imm_q[5:0]}; dp_w = 1'b1;
          end
          OP_LSR: begin
            dp_fs = FS_LSR; dp_s = 1'b1; dp_k = {58'd0, imm_q[5:0]}; dp_w = 1'b1;
          end
          OP_ADDI: begin
            dp_fs = FS_ADD; dp_s = 1'b1; dp_k = {48'd0, imm_q}; dp_w = 1'b1;
          end
          OP_SUBI: begin
            dp_fs = FS_SUB; dp_c0 = 1'b1; dp_s = 1'b1; dp_k = {48'd0, imm_q}; dp_w = 1'b1;
          end
          OP_CMP:  begin dp_fs = FS_SUB; dp_c0 = 1'b1; end
          default: begin
            dp_sd = 1'b0; dp_addrA = '0; dp_addrB = '0; dp_addrR = '0;
          end
        endcase
      end
      M_CLR: begin
        dp_addrR = rd_q; dp_addrA = XZR_A; dp_s = 1'b1; dp_k = '0;
        dp_fs = FS_ADD; dp_sd = 1'b1; dp_w = 1'b1;
      end
      M_SHF: begin
        if (cur_bit) begin
          dp_addrR = SCR_A; dp_addrA = rn_q; dp_fs = FS_LSL; dp_s = 1'b1;
          dp_k = 64'(bit_q); dp_sd = 1'b1; dp_w = 1'b1;
        end
      end
      M_ACC: begin
        dp_addrR = rd_q; dp_addrA = rd_q; dp_addrB = SCR_A;
        dp_fs = FS_ADD; dp_sd = 1'b1; dp_w = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: drives dp_sequencer against a small behavioural alu_reg
// model; a scoreboard predicts each response's error bit, busy length and
// number of register writes, and register contents are probed directly.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [15:0] cmd_imm;
  logic        busy, rsp_valid, rsp_err;
  logic [3:0]  flags;
  logic [3:0]  dp_status;
  logic [63:0] dp_k;
  logic [4:0]  dp_fs, dp_addrR, dp_addrA, dp_addrB;
  logic        dp_s, dp_sd, dp_sb, dp_c0, dp_w;

  int check_count = 0;
  int error_count = 0;
  int cmd_id      = 0;
  int busy_cnt    = 0;
  int w_cnt       = 0;

  typedef struct {
    int   id;
    logic err;
    int   busy_n;
    int   w_n;
  } exp_t;
  exp_t exp_q[$];

  logic [63:0] reg_file [0:31] = '{default: 64'd0};
  logic [63:0] alu_a, alu_b, alu_f;
  logic        alu_c, alu_v;

  dp_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .flags(flags), .dp_status(dp_status), .dp_k(dp_k), .dp_fs(dp_fs),
    .dp_addrR(dp_addrR), .dp_addrA(dp_addrA), .dp_addrB(dp_addrB),
    .dp_s(dp_s), .dp_sd(dp_sd), .dp_sb(dp_sb), .dp_c0(dp_c0), .dp_w(dp_w)
  );

  always #5 clk = ~clk;

  // Behavioural alu_reg: combinational ALU and status {V,C,N,Z}.
  always_comb begin
    alu_a = (dp_addrA == 5'd31) ? 64'd0 : reg_file[dp_addrA];
    alu_b = dp_s ? dp_k : ((dp_addrB == 5'd31) ? 64'd0 : reg_file[dp_addrB]);
    if (dp_fs[1]) alu_a = ~alu_a;
    if (dp_fs[0]) alu_b = ~alu_b;
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (dp_fs[4:2])
      3'b000: alu_f = alu_a & alu_b;
      3'b001: alu_f = alu_a | alu_b;
      3'b010: begin
        {alu_c, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {64'd0, dp_c0};
        alu_v = (alu_a[63] == alu_b[63]) && (alu_f[63] != alu_a[63]);
      end
      3'b011: alu_f = alu_a ^ alu_b;
      3'b100: alu_f = alu_a << alu_b[5:0];
      3'b101: alu_f = alu_a >> alu_b[5:0];
      default: alu_f = '0;
    endcase
    dp_status = {alu_v, alu_c, alu_f[63], (alu_f == 64'd0)};
  end

  // Register file write port; XZR writes are dropped.
  always @(posedge clk) begin
    if (dp_w && dp_addrR != 5'd31) reg_file[dp_addrR] <= dp_sd ? alu_f : 64'd0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    check_count++;
    if (obs !== exp_v) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      w_cnt    = 0;
    end else begin
      if (dp_w) w_cnt++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput($sformatf("cmd%0d rsp_err", e.id), 64'(rsp_err), 64'(e.err));
          checkOutput($sformatf("cmd%0d busy cycles", e.id), 64'(busy_cnt), 64'(e.busy_n));
          checkOutput($sformatf("cmd%0d writes", e.id), 64'(w_cnt), 64'(e.w_n));
        end
        busy_cnt = 0;
        w_cnt    = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                               input logic [4:0] rm, input logic [15:0] imm,
                               input logic exp_err, input int exp_busy, input int exp_w);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) checkOutput("cmd_ready timeout", 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
    cmd_valid = 1'b1;
    cmd_id++;
    e.id = cmd_id; e.err = exp_err; e.busy_n = exp_busy; e.w_n = exp_w;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("rsp timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset flags", 64'(flags), 64'd0);
    checkOutput("reset fs", 64'(dp_fs), 64'b01000);
    checkOutput("reset w", 64'(dp_w), 64'd0);
    checkOutput("reset k", dp_k, 64'd0);
    checkOutput("reset ctl", 64'({dp_s, dp_sd, dp_sb, dp_c0, dp_addrR, dp_addrA, dp_addrB}), 64'd0);

    // Basic loads and add
    applyStimulus(4'd1, 5'd0, 5'd0, 5'd0, 16'd916, 1'b0, 1, 1);
    applyStimulus(4'd1, 5'd1, 5'd0, 5'd0, 16'd619, 1'b0, 1, 1);
    applyStimulus(4'd2, 5'd20, 5'd0, 5'd1, 16'd0, 1'b0, 1, 1);
    checkOutput("R0", reg_file[0], 64'd916);
    checkOutput("R1", reg_file[1], 64'd619);
    checkOutput("R20 add", reg_file[20], 64'd1535);

    // Logic and shifts
    applyStimulus(4'd1, 5'd3, 5'd0, 5'd0, 16'h57, 1'b0, 1, 1);
    applyStimulus(4'd1, 5'd5, 5'd0, 5'd0, 16'd7, 1'b0, 1, 1);
    applyStimulus(4'd4, 5'd21, 5'd3, 5'd5, 16'd0, 1'b0, 1, 1);
    applyStimulus(4'd7, 5'd22, 5'd5, 5'd0, 16'd3, 1'b0, 1, 1);
    applyStimulus(4'd8, 5'd23, 5'd22, 5'd0, 16'hFF02, 1'b0, 1, 1);
    checkOutput("R21 and", reg_file[21], 64'd7);
    checkOutput("R22 lsl", reg_file[22], 64'd56);
    checkOutput("R23 lsr", reg_file[23], 64'd14);

    // Remaining single-word arithmetic and NOP
    applyStimulus(4'd3, 5'd25, 5'd0, 5'd1, 16'd0, 1'b0, 1, 1);
    applyStimulus(4'd5, 5'd26, 5'd3, 5'd5, 16'd0, 1'b0, 1, 1);
    applyStimulus(4'd6, 5'd7, 5'd3, 5'd5, 16'd0, 1'b0, 1, 1);
    applyStimulus(4'd9, 5'd8, 5'd1, 5'd0, 16'd100, 1'b0, 1, 1);
    applyStimulus(4'd10, 5'd9, 5'd0, 5'd0, 16'd16, 1'b0, 1, 1);
    applyStimulus(4'd0, 5'd11, 5'd0, 5'd1, 16'd5, 1'b0, 1, 0);
    checkOutput("R25 sub", reg_file[25], 64'd297);
    checkOutput("R26 orr", reg_file[26], 64'h57);
    checkOutput("R7 eor", reg_file[7], 64'h50);
    checkOutput("R8 addi", reg_file[8], 64'd719);
    checkOutput("R9 subi", reg_file[9], 64'd900);
    checkOutput("R11 nop", reg_file[11], 64'd0);

    // Compare captures status; other ops leave flags alone
    applyStimulus(4'd11, 5'd0, 5'd1, 5'd1, 16'd0, 1'b0, 1, 0);
    checkOutput("flags cmp eq", 64'(flags), 64'h5);
    checkOutput("R0 after cmp", reg_file[0], 64'd916);
    applyStimulus(4'd11, 5'd1, 5'd0, 5'd1, 16'd0, 1'b0, 1, 0);
    checkOutput("flags cmp ne", 64'(flags), 64'h4);
    checkOutput("R1 after cmp", reg_file[1], 64'd619);
    applyStimulus(4'd2, 5'd24, 5'd0, 5'd1, 16'd0, 1'b0, 1, 1);
    checkOutput("flags after add", 64'(flags), 64'h4);
    checkOutput("R24 add", reg_file[24], 64'd1535);

    // Multiply by immediate
    applyStimulus(4'd12, 5'd2, 5'd1, 5'd0, 16'd5, 1'b0, 9, 5);
    checkOutput("R2 muli5", reg_file[2], 64'd3095);
    checkOutput("R27 muli5", reg_file[27], 64'd2476);
    applyStimulus(4'd12, 5'd10, 5'd1, 5'd0, 16'hFF21, 1'b0, 9, 5);
    checkOutput("R10 muli33", reg_file[10], 64'd20427);
    checkOutput("R27 muli33", reg_file[27], 64'd19808);
    applyStimulus(4'd12, 5'd2, 5'd1, 5'd0, 16'd0, 1'b0, 7, 1);
    checkOutput("R2 muli0", reg_file[2], 64'd0);

    // Rejected commands
    applyStimulus(4'd14, 5'd2, 5'd1, 5'd1, 16'd9, 1'b1, 0, 0);
    applyStimulus(4'd12, 5'd4, 5'd4, 5'd0, 16'd3, 1'b1, 0, 0);
    applyStimulus(4'd12, 5'd27, 5'd1, 5'd0, 16'd3, 1'b1, 0, 0);
    applyStimulus(4'd12, 5'd2, 5'd27, 5'd0, 16'd3, 1'b1, 0, 0);
    checkOutput("R2 after err", reg_file[2], 64'd0);
    checkOutput("R4 after err", reg_file[4], 64'd0);
    checkOutput("R27 after err", reg_file[27], 64'd19808);

    // Abort a MULI with reset during its third busy cycle
    @(negedge clk);
    cmd_op = 4'd12; cmd_rd = 5'd2; cmd_rn = 5'd1; cmd_rm = 5'd0; cmd_imm = 16'd63;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort w", 64'(dp_w), 64'd0);
    checkOutput("abort rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort flags", 64'(flags), 64'd0);
    checkOutput("R27 after abort", reg_file[27], 64'd619);
    repeat (3) @(negedge clk);
    applyStimulus(4'd1, 5'd6, 5'd0, 5'd0, 16'd42, 1'b0, 1, 1);
    checkOutput("R6 after abort", reg_file[6], 64'd42);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
